// File: rtl/biquad_coeff_sequencer_pkg.sv
// Shared constants, FSM encoding and mask-scan helper for the biquad coefficient sequencer.
package biquad_coeff_sequencer_pkg;

    localparam int CBITS_DEFAULT = 18;
    localparam int MAX_FILT      = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        UPDATE,
        DONE
    } state_t;

    // Lowest set bit of mask at or above start, or limit when none remain.
    function automatic int next_set(input logic [MAX_FILT-1:0] mask, input int start, input int limit);
        int r;
        r = limit;
        for (int i = MAX_FILT - 1; i >= 0; i--) begin
            if (i < limit && i >= start && mask[i]) begin
                r = i;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/biquad_coeff_shadow.sv
// Shadow coefficient register file: synchronous write, asynchronous read, address range check.
module biquad_coeff_shadow
    import biquad_coeff_sequencer_pkg::*;
#(
    parameter int NFILT   = 2,
    parameter int NCOEFF  = 2,
    parameter int CBITS   = CBITS_DEFAULT,
    parameter int ADRBITS = $clog2(NFILT*NCOEFF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [ADRBITS-1:0] wr_adr,
    input  logic [CBITS-1:0]   wr_dat,
    input  logic [ADRBITS-1:0] rd_adr,
    output logic [CBITS-1:0]   rd_dat,
    output logic               adr_ok
);

    localparam int DEPTH = NFILT * NCOEFF;

    logic [CBITS-1:0] mem [DEPTH];

    assign adr_ok = (32'(wr_adr) < DEPTH);
    assign rd_dat = mem[rd_adr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en && adr_ok) begin
            mem[wr_adr] <= wr_dat;
        end
    end

endmodule

// File: rtl/biquad_coeff_sequencer.sv
// Loads shadowed coefficients into the B1 cascades of selected biquads, then swaps B2 atomically.
module biquad_coeff_sequencer
    import biquad_coeff_sequencer_pkg::*;
#(
    parameter int NFILT  = 2,
    parameter int NCOEFF = 2,
    parameter int CBITS  = CBITS_DEFAULT,
    localparam int ADRBITS = $clog2(NFILT*NCOEFF)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADRBITS-1:0] cfg_adr_i,
    input  logic [CBITS-1:0]   cfg_dat_i,
    input  logic               cfg_wr_i,
    input  logic               commit_i,
    input  logic [NFILT-1:0]   commit_mask_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [CBITS-1:0]   coeff_dat_o,
    output logic [NFILT-1:0]   coeff_wr_o,
    output logic [NFILT-1:0]   coeff_update_o
);

    localparam int FW = $clog2(NFILT + 1);
    localparam int CW = $clog2(NCOEFF + 1);

    state_t             state, state_nxt;
    logic [NFILT-1:0]   mask_q;
    logic [FW-1:0]      filt;
    logic [CW-1:0]      coeff;
    int                 nxt_filt;
    logic               last_word;
    logic [ADRBITS-1:0] rd_adr;
    logic [CBITS-1:0]   rd_dat;
    logic               adr_ok;
    logic               err_q;
    logic [CBITS-1:0]   dat_q;

    assign rd_adr = ADRBITS'(int'(filt) * NCOEFF + int'(coeff));

    biquad_coeff_shadow #(
        .NFILT   (NFILT),
        .NCOEFF  (NCOEFF),
        .CBITS   (CBITS),
        .ADRBITS (ADRBITS)
    ) u_shadow (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (cfg_wr_i && !busy_o),
        .wr_adr (cfg_adr_i),
        .wr_dat (cfg_dat_i),
        .rd_adr (rd_adr),
        .rd_dat (rd_dat),
        .adr_ok (adr_ok)
    );

    always_comb begin
        nxt_filt       = next_set(MAX_FILT'(mask_q), int'(filt) + 1, NFILT);
        last_word      = (coeff == '0) && (nxt_filt >= NFILT);
        state_nxt      = state;
        busy_o         = 1'b0;
        done_o         = 1'b0;
        coeff_wr_o     = '0;
        coeff_update_o = '0;
        case (state)
            IDLE: begin
                if (commit_i) begin
                    state_nxt = (commit_mask_i != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                busy_o     = 1'b1;
                coeff_wr_o = NFILT'(1) << filt;
                if (last_word) begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                busy_o    = 1'b1;
                state_nxt = UPDATE;
            end
            UPDATE: begin
                busy_o         = 1'b1;
                coeff_update_o = mask_q;
                state_nxt      = DONE;
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Data trails its write strobe by one cycle because the filter registers coeff_wr_i internally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            mask_q <= '0;
            filt   <= '0;
            coeff  <= '0;
            dat_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            err_q <= (cfg_wr_i && (busy_o || !adr_ok)) || (commit_i && state != IDLE);
            if (state == IDLE && commit_i) begin
                mask_q <= commit_mask_i;
                filt   <= FW'(next_set(MAX_FILT'(commit_mask_i), 0, NFILT));
                coeff  <= CW'(NCOEFF - 1);
            end else if (state == LOAD) begin
                dat_q <= rd_dat;
                if (coeff == '0) begin
                    if (nxt_filt < NFILT) begin
                        filt <= FW'(nxt_filt);
                    end
                    coeff <= CW'(NCOEFF - 1);
                end else begin
                    coeff <= coeff - CW'(1);
                end
            end
        end
    end

    assign err_o       = err_q;
    assign coeff_dat_o = dat_q;

endmodule

// File: tb/tb_biquad_coeff_sequencer.sv
// Directed scoreboard bench for biquad_coeff_sequencer with a golden B1/B2 cascade model.
module tb_biquad_coeff_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cfg_adr_i;
    logic [17:0] cfg_dat_i;
    logic        cfg_wr_i;
    logic        commit_i;
    logic [1:0]  commit_mask_i;
    logic        busy_o, done_o, err_o;
    logic [17:0] coeff_dat_o;
    logic [1:0]  coeff_wr_o, coeff_update_o;

    // Three-filter instance so that out-of-range addresses are representable.
    logic [2:0]  cfg_adr3;
    logic [17:0] cfg_dat3;
    logic        cfg_wr3, commit3;
    logic [2:0]  mask3;
    logic        busy3, done3, err3;
    logic [17:0] dat3;
    logic [2:0]  wr3, upd3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  wr;
        logic        dat_v;
        logic [17:0] dat;
        logic [1:0]  upd;
        logic        busy;
        logic        done;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [17:0] sh[4];
    logic [17:0] b1[2][2];
    logic [17:0] b2[2][2];
    logic [1:0]  wr_prev = '0;

    always #5 clk = ~clk;

    biquad_coeff_sequencer #(.NFILT(2), .NCOEFF(2), .CBITS(18)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_adr_i      (cfg_adr_i),
        .cfg_dat_i      (cfg_dat_i),
        .cfg_wr_i       (cfg_wr_i),
        .commit_i       (commit_i),
        .commit_mask_i  (commit_mask_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .coeff_dat_o    (coeff_dat_o),
        .coeff_wr_o     (coeff_wr_o),
        .coeff_update_o (coeff_update_o)
    );

    biquad_coeff_sequencer #(.NFILT(3), .NCOEFF(2), .CBITS(18)) dut3 (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_adr_i      (cfg_adr3),
        .cfg_dat_i      (cfg_dat3),
        .cfg_wr_i       (cfg_wr3),
        .commit_i       (commit3),
        .commit_mask_i  (mask3),
        .busy_o         (busy3),
        .done_o         (done3),
        .err_o          (err3),
        .coeff_dat_o    (dat3),
        .coeff_wr_o     (wr3),
        .coeff_update_o (upd3)
    );

    // Golden filter side: registered wr strobe shifts low->high B1 with the current data; update copies B1 to B2.
    always @(negedge clk) begin
        for (int f = 0; f < 2; f++) begin
            if (wr_prev[f]) begin
                b1[f][1] = b1[f][0];
                b1[f][0] = coeff_dat_o;
            end
            if (coeff_update_o[f]) begin
                b2[f] = b1[f];
            end
        end
        wr_prev = coeff_wr_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_trace(input logic [1:0] mask);
        logic [17:0] words[$];
        logic [1:0]  wrs[$];
        exp_t        e;
        int          len;
        for (int f = 0; f < 2; f++) begin
            if (mask[f]) begin
                for (int c = 1; c >= 0; c--) begin
                    words.push_back(sh[f*2 + c]);
                    wrs.push_back(2'(1 << f));
                end
            end
        end
        len = words.size();
        if (len == 0) begin
            e = '{wr: 2'b00, dat_v: 1'b0, dat: 18'h0, upd: 2'b00, busy: 1'b0, done: 1'b1, err: 1'b0};
            exp_q.push_back(e);
        end else begin
            for (int cyc = 1; cyc <= len + 3; cyc++) begin
                e = '{wr: 2'b00, dat_v: 1'b0, dat: 18'h0, upd: 2'b00, busy: 1'b0, done: 1'b0, err: 1'b0};
                if (cyc <= len) e.wr = wrs[cyc-1];
                if (cyc >= 2) begin
                    e.dat_v = 1'b1;
                    e.dat   = (cyc <= len + 1) ? words[cyc-2] : words[len-1];
                end
                e.busy = (cyc <= len + 2);
                e.upd  = (cyc == len + 2) ? mask : 2'b00;
                e.done = (cyc == len + 3);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic run(input logic [1:0] mask, input bit wr_now, input logic [1:0] wadr,
                       input logic [17:0] wdat, input bit reject, input int abort_at);
        exp_t e;
        int   n;
        @(negedge clk);
        commit_i      = 1'b1;
        commit_mask_i = mask;
        if (wr_now) begin
            cfg_wr_i  = 1'b1;
            cfg_adr_i = wadr;
            cfg_dat_i = wdat;
            sh[wadr]  = wdat;
        end
        push_trace(mask);
        if (reject) begin
            exp_q[2].err = 1'b1;
            exp_q[3].err = 1'b1;
        end
        n = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            n++;
            commit_i = 1'b0;
            cfg_wr_i = 1'b0;
            if (reject && n == 2) begin
                cfg_wr_i  = 1'b1;
                cfg_adr_i = 2'd0;
                cfg_dat_i = 18'h2AAAA;
            end
            if (reject && n == 3) begin
                commit_i      = 1'b1;
                commit_mask_i = 2'b11;
            end
            e = exp_q.pop_front();
            check($sformatf("m%0b c%0d wr", mask, n), 32'(coeff_wr_o), 32'(e.wr));
            check($sformatf("m%0b c%0d upd", mask, n), 32'(coeff_update_o), 32'(e.upd));
            check($sformatf("m%0b c%0d busy", mask, n), 32'(busy_o), 32'(e.busy));
            check($sformatf("m%0b c%0d done", mask, n), 32'(done_o), 32'(e.done));
            check($sformatf("m%0b c%0d err", mask, n), 32'(err_o), 32'(e.err));
            if (e.dat_v) check($sformatf("m%0b c%0d dat", mask, n), 32'(coeff_dat_o), 32'(e.dat));
            if (abort_at == n) begin
                rst_n = 1'b0;
                exp_q.delete();
            end
        end
        commit_i = 1'b0;
        cfg_wr_i = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] adr, input logic [17:0] dat);
        @(negedge clk);
        cfg_wr_i  = 1'b1;
        cfg_adr_i = adr;
        cfg_dat_i = dat;
        sh[adr]   = dat;
        @(negedge clk);
        cfg_wr_i = 1'b0;
        check($sformatf("wr%0d err", adr), 32'(err_o), 32'd0);
    endtask

    task automatic load_scenario_set();
        cfg_write(2'd0, 18'h00011);
        cfg_write(2'd1, 18'h00022);
        cfg_write(2'd2, 18'h00033);
        cfg_write(2'd3, 18'h00044);
    endtask

    task automatic check_b2(input string tag, input logic [17:0] lo0, input logic [17:0] hi0,
                            input logic [17:0] lo1, input logic [17:0] hi1);
        check({tag, " f0 low"},  32'(b2[0][0]), 32'(lo0));
        check({tag, " f0 high"}, 32'(b2[0][1]), 32'(hi0));
        check({tag, " f1 low"},  32'(b2[1][0]), 32'(lo1));
        check({tag, " f1 high"}, 32'(b2[1][1]), 32'(hi1));
    endtask

    task automatic wr3_cycle(input logic [2:0] adr, input logic [17:0] dat, input logic exp_err);
        @(negedge clk);
        cfg_wr3  = 1'b1;
        cfg_adr3 = adr;
        cfg_dat3 = dat;
        @(negedge clk);
        cfg_wr3 = 1'b0;
        check($sformatf("dut3 wr%0d err", adr), 32'(err3), 32'(exp_err));
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_adr_i = '0; cfg_dat_i = '0; cfg_wr_i = 1'b0; commit_i = 1'b0; commit_mask_i = '0;
        cfg_adr3 = '0; cfg_dat3 = '0; cfg_wr3 = 1'b0; commit3 = 1'b0; mask3 = '0;
        for (int i = 0; i < 4; i++) sh[i] = '0;
        for (int f = 0; f < 2; f++) begin
            b1[f] = '{18'h0, 18'h0};
            b2[f] = '{18'h0, 18'h0};
        end
        repeat (3) @(negedge clk);
        check("rst busy", 32'(busy_o), 32'd0);
        check("rst done", 32'(done_o), 32'd0);
        check("rst err", 32'(err_o), 32'd0);
        check("rst dat", 32'(coeff_dat_o), 32'd0);
        check("rst wr", 32'(coeff_wr_o), 32'd0);
        check("rst upd", 32'(coeff_update_o), 32'd0);
        rst_n = 1'b1;

        // Basic load of both filters
        load_scenario_set();
        run(2'b11, 1'b0, 2'd0, 18'h0, 1'b0, 0);
        check_b2("s1", 18'h00011, 18'h00022, 18'h00033, 18'h00044);

        // Single filter
        run(2'b10, 1'b0, 2'd0, 18'h0, 1'b0, 0);

        // Rejected write and commit while busy, then readback via a full commit
        run(2'b11, 1'b0, 2'd0, 18'h0, 1'b1, 0);
        repeat (3) begin
            @(negedge clk);
            check("post-reject done", 32'(done_o), 32'd0);
            check("post-reject busy", 32'(busy_o), 32'd0);
        end
        run(2'b11, 1'b0, 2'd0, 18'h0, 1'b0, 0);

        // Empty mask
        run(2'b00, 1'b0, 2'd0, 18'h0, 1'b0, 0);

        // Out-of-range addresses on the six-entry instance
        wr3_cycle(3'd6, 18'h00001, 1'b1);
        @(negedge clk);
        check("dut3 err one-shot", 32'(err3), 32'd0);
        wr3_cycle(3'd5, 18'h00005, 1'b0);
        wr3_cycle(3'd7, 18'h00007, 1'b1);
        @(negedge clk);
        commit3 = 1'b1;
        mask3   = 3'b100;
        @(negedge clk);
        commit3 = 1'b0;
        check("dut3 c1 wr", 32'(wr3), 32'd4);
        @(negedge clk);
        check("dut3 c2 dat", 32'(dat3), 32'h5);
        @(negedge clk);
        check("dut3 c3 dat", 32'(dat3), 32'h0);
        @(negedge clk);
        check("dut3 c4 upd", 32'(upd3), 32'd4);
        @(negedge clk);
        check("dut3 c5 done", 32'(done3), 32'd1);

        // Reset in the middle of a load
        run(2'b11, 1'b0, 2'd0, 18'h0, 1'b0, 3);
        @(negedge clk);
        check("abort busy", 32'(busy_o), 32'd0);
        check("abort done", 32'(done_o), 32'd0);
        check("abort err", 32'(err_o), 32'd0);
        check("abort dat", 32'(coeff_dat_o), 32'd0);
        check("abort wr", 32'(coeff_wr_o), 32'd0);
        check("abort upd", 32'(coeff_update_o), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) sh[i] = '0;
        repeat (4) begin
            @(negedge clk);
            check("abort no upd", 32'(coeff_update_o), 32'd0);
        end
        check_b2("abort b2 kept", 18'h00011, 18'h00022, 18'h00033, 18'h00044);
        load_scenario_set();
        run(2'b11, 1'b0, 2'd0, 18'h0, 1'b0, 0);
        check_b2("recommit", 18'h00011, 18'h00022, 18'h00033, 18'h00044);

        // Write and commit in the same cycle
        run(2'b01, 1'b1, 2'd1, 18'h3FFFF, 1'b0, 0);
        check_b2("same-cycle", 18'h00011, 18'h3FFFF, 18'h00033, 18'h00044);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
